instruction_cache: RTL

//  Direct-mapped, read-only instruction cache between the IF stage and instruction_memory.
//  On a hit, returns the 32-bit instruction in the same cycle.
//  On a miss, stalls the CPU and acts as initiator of a 16-byte block read (READ/ADDRESS/READDATA/BUSYWAIT).

---
 rtl/instruction_cache_pkg.sv | 21 ++
 rtl/instruction_cache_if.sv | 25 ++
 rtl/icache_line_array.sv | 51 +++++
 rtl/instruction_cache.sv | 106 ++++++++++
 4 files changed

// File: rtl/instruction_cache_pkg.sv
// Shared constants, FSM encoding and helpers for the instruction cache.
package instruction_cache_pkg;

  localparam int BLOCK_BYTES   = 16;
  localparam int BLOCK_BITS    = 128;
  localparam int WORD_BITS     = 32;
  localparam int MEM_ADDR_BITS = 28;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_RD = 2'd1,
    FILL   = 2'd2
  } state_t;

  // Picks one 32-bit word out of a 16-byte block; byte k sits at bits [8k+7:8k].
  function automatic logic [WORD_BITS-1:0] select_word(input logic [BLOCK_BITS-1:0] blk,
                                                       input logic [1:0] sel);
    return blk[sel*WORD_BITS +: WORD_BITS];
  endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// Bus bundle between the IF stage, the cache and instruction memory.
// The slave side is the cache itself; the master side is everything around it.
interface instruction_cache_if;
  import instruction_cache_pkg::*;

  logic [31:0]              PC_ADDRESS;
  logic                     CPU_READ;
  logic [WORD_BITS-1:0]     INSTRUCTION;
  logic                     CPU_BUSYWAIT;
  logic                     MEM_READ;
  logic [MEM_ADDR_BITS-1:0] MEM_ADDRESS;
  logic [BLOCK_BITS-1:0]    MEM_READDATA;
  logic                     MEM_BUSYWAIT;

  modport slave (
    input  PC_ADDRESS, CPU_READ, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, CPU_BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

  modport master (
    output PC_ADDRESS, CPU_READ, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, CPU_BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

endinterface

// File: rtl/icache_line_array.sv
// Line storage for the direct-mapped cache: VALID bits, tags and data blocks.
// Only VALID is reset; tag and data contents are meaningless until VALID is set.
module icache_line_array
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = MEM_ADDR_BITS - INDEX_BITS
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [BLOCK_BITS-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [BLOCK_BITS-1:0] wr_data
);

  localparam int NUM_LINES = 2 ** INDEX_BITS;

  logic [NUM_LINES-1:0]  valid_bits;
  logic [TAG_BITS-1:0]   tag_mem  [NUM_LINES];
  logic [BLOCK_BITS-1:0] data_mem [NUM_LINES];

  // VALID bits clear on reset so an abandoned or stale line can never hit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_index] <= 1'b1;
    end
  end

  // Tag and data are plain storage, written only when a fill completes.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  // Combinational read port so a hit returns its word in the same cycle.
  always_comb begin
    rd_valid = valid_bits[rd_index];
    rd_tag   = tag_mem[rd_index];
    rd_data  = data_mem[rd_index];
  end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache. Hits answer combinationally;
// misses stall the CPU, fetch a 16-byte block and refill the line.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_BITS = 3
) (
  input logic                  CLK,
  input logic                  RESET,
  instruction_cache_if.slave   bus
);

  localparam int TAG_BITS = MEM_ADDR_BITS - INDEX_BITS;

  state_t                   state;
  state_t                   next_state;
  logic                     rd_wait_done;
  logic [MEM_ADDR_BITS-1:0] miss_addr;

  logic [INDEX_BITS-1:0]    pc_index;
  logic [TAG_BITS-1:0]      pc_tag;
  logic [1:0]               pc_word;
  logic                     line_valid;
  logic [TAG_BITS-1:0]      line_tag;
  logic [BLOCK_BITS-1:0]    line_data;
  logic                     hit;
  logic                     fill_en;
  logic [1:0]               unused_pc_byte;

  assign pc_index       = bus.PC_ADDRESS[3+INDEX_BITS:4];
  assign pc_tag         = bus.PC_ADDRESS[31:4+INDEX_BITS];
  assign pc_word        = bus.PC_ADDRESS[3:2];
  assign unused_pc_byte = bus.PC_ADDRESS[1:0];
  assign fill_en        = (state == FILL);

  icache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_lines (
    .CLK      (CLK),
    .RESET    (RESET),
    .rd_index (pc_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (fill_en),
    .wr_index (miss_addr[INDEX_BITS-1:0]),
    .wr_tag   (miss_addr[MEM_ADDR_BITS-1:INDEX_BITS]),
    .wr_data  (bus.MEM_READDATA)
  );

  // Hit detection and word selection for the current PC.
  always_comb begin
    hit             = bus.CPU_READ & line_valid & (line_tag == pc_tag);
    bus.INSTRUCTION = hit ? select_word(line_data, pc_word) : '0;
  end

  // State register; reset abandons any in-flight miss.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Miss address latch plus a flag marking that one full cycle has been spent in MEM_RD,
  // since memory only raises its busy flag after seeing the read request.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      miss_addr    <= '0;
      rd_wait_done <= 1'b0;
    end else begin
      rd_wait_done <= (state == MEM_RD);
      if (state == IDLE && bus.CPU_READ && !hit) begin
        miss_addr <= bus.PC_ADDRESS[31:4];
      end
    end
  end

  // Next-state logic: miss -> block read -> fill -> back to lookup.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.CPU_READ && !hit) next_state = MEM_RD;
      MEM_RD:  if (rd_wait_done && !bus.MEM_BUSYWAIT) next_state = FILL;
      FILL:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: stall while a miss is outstanding, request memory only in MEM_RD.
  always_comb begin
    bus.CPU_BUSYWAIT = 1'b1;
    bus.MEM_READ     = 1'b0;
    case (state)
      IDLE:    bus.CPU_BUSYWAIT = bus.CPU_READ & ~hit;
      MEM_RD:  bus.MEM_READ     = 1'b1;
      FILL:    bus.CPU_BUSYWAIT = 1'b1;
      default: bus.CPU_BUSYWAIT = 1'b1;
    endcase
  end

  assign bus.MEM_ADDRESS = miss_addr;

endmodule
